mrc_lane_sched: RTL and testbench

Memory-read lane scheduler for the manager's stack-bus downstream path. It accepts one decoded memory-read descriptor at a time (lane mask, base address, per-lane stride, word count) from the memory read controller's descriptor pipe. It then drives an independent address stream onto each enabled execution lane of the stack-down interface, framing each stream with start/middle/end control codes. The descriptor retires when every enabled lane has delivered its last beat.

---
 rtl/mrc_lane_sched_if.sv | 27 ++
 rtl/mrc_lane_sched.sv | 125 ++++++++++++
 tb/tb_mrc_lane_sched.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mrc_lane_sched_if.sv
// Descriptor and stack-down lane bus for mrc_lane_sched.
// The master modport is the scheduler side. The slave modport is the descriptor source plus the lane sink.
interface mrc_lane_sched_if #(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int CNT_WIDTH  = 12
);
  logic                            desc_valid;
  logic                            desc_ready;
  logic [NUM_LANES-1:0]            desc_lane_mask;
  logic [ADDR_WIDTH-1:0]           desc_base_addr;
  logic [ADDR_WIDTH-1:0]           desc_lane_stride;
  logic [CNT_WIDTH-1:0]            desc_num_words;
  logic [NUM_LANES-1:0]            lane_valid;
  logic [2*NUM_LANES-1:0]          lane_cntl;
  logic [ADDR_WIDTH*NUM_LANES-1:0] lane_data;
  logic [NUM_LANES-1:0]            lane_ready;

  modport master (
    input  desc_valid, desc_lane_mask, desc_base_addr, desc_lane_stride, desc_num_words, lane_ready,
    output desc_ready, lane_valid, lane_cntl, lane_data
  );
  modport slave (
    output desc_valid, desc_lane_mask, desc_base_addr, desc_lane_stride, desc_num_words, lane_ready,
    input  desc_ready, lane_valid, lane_cntl, lane_data
  );
endinterface

// File: rtl/mrc_lane_sched.sv
// Memory-read lane scheduler: one descriptor at a time fans out into independent,
// framed address streams, one stream per enabled stack-down lane.
module mrc_lane_sched_lane #(
  parameter int ADDR_WIDTH = 24,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic                  ready,
  output logic                  valid,
  output logic [1:0]            cntl,
  output logic [ADDR_WIDTH-1:0] data,
  output logic                  idle_next
);
  logic [CNT_WIDTH-1:0] remaining;
  logic fire, last;

  assign fire      = valid & ready;
  assign last      = (remaining == CNT_WIDTH'(1));
  assign idle_next = ~valid | (fire & last);

  // remaining counts the beats still to go, including the beat currently presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      cntl      <= 2'b00;
      data      <= '0;
      remaining <= '0;
    end else if (load) begin
      valid     <= 1'b1;
      data      <= base;
      remaining <= num_words;
      cntl      <= (num_words == CNT_WIDTH'(1)) ? 2'b11 : 2'b01;
    end else if (fire) begin
      if (last) begin
        valid <= 1'b0;
        cntl  <= 2'b00;
      end else begin
        data      <= data + ADDR_WIDTH'(1);
        remaining <= remaining - CNT_WIDTH'(1);
        cntl      <= (remaining == CNT_WIDTH'(2)) ? 2'b10 : 2'b00;
      end
    end
  end
endmodule

module mrc_lane_sched #(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int CNT_WIDTH  = 12
) (
  input  logic              clk,
  input  logic              reset_poweron,
  mrc_lane_sched_if.master  bus,
  output logic              busy,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  state_t state;

  logic desc_ready_q, accept, bad;
  logic [NUM_LANES-1:0]                 load, idle_next, valid_a;
  logic [NUM_LANES-1:0][1:0]            cntl_a;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] data_a, base_a;

  assign accept         = bus.desc_valid & desc_ready_q;
  assign bad            = (bus.desc_num_words == '0) | (bus.desc_lane_mask == '0);
  assign bus.desc_ready = desc_ready_q;
  assign bus.lane_valid = valid_a;
  assign bus.lane_cntl  = cntl_a;
  assign bus.lane_data  = data_a;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign base_a[i] = bus.desc_base_addr + ADDR_WIDTH'(i) * bus.desc_lane_stride;
    assign load[i]   = accept & ~bad & bus.desc_lane_mask[i];
    mrc_lane_sched_lane #(.ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_lane (
      .clk       (clk),
      .rst       (reset_poweron),
      .load      (load[i]),
      .base      (base_a[i]),
      .num_words (bus.desc_num_words),
      .ready     (bus.lane_ready[i]),
      .valid     (valid_a[i]),
      .cntl      (cntl_a[i]),
      .data      (data_a[i]),
      .idle_next (idle_next[i])
    );
  end

  // desc_ready is held low through reset and rises on the first edge after reset is released.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state        <= IDLE;
      desc_ready_q <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          desc_ready_q <= 1'b1;
          if (accept) begin
            desc_ready_q <= 1'b0;
            if (bad) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: if (&idle_next) begin
          state        <= IDLE;
          busy         <= 1'b0;
          desc_ready_q <= 1'b1;
        end
        ERR: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mrc_lane_sched.sv
// Directed and random descriptor traffic for mrc_lane_sched.
// Expected outputs come from a per-lane (base, position, length) stream model.
module tb_mrc_lane_sched;
  localparam int NL = 4, AW = 24, CW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;

  mrc_lane_sched_if #(.NUM_LANES(NL), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  mrc_lane_sched #(.NUM_LANES(NL), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_poweron(rst), .bus(bus), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Stream model: lane i still owes beats m_pos[i] .. m_len[i]-1, where beat k carries address m_base[i]+k.
  logic [AW-1:0] m_base [NL];
  int  m_pos [NL];
  int  m_len [NL];
  bit  m_err, m_armed, acc_seen;
  int  ready_mode, stall_left;

  function automatic bit m_busy();
    for (int i = 0; i < NL; i++) if (m_pos[i] < m_len[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_cntl(int pos, int len);
    if (len == 1) return 2'b11;
    if (pos == 0) return 2'b01;
    if (pos == len - 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_err = 1'b0; m_armed = 1'b0;
    for (int i = 0; i < NL; i++) begin m_pos[i] = 0; m_len[i] = 0; m_base[i] = '0; end
  endtask

  // The bench is at a falling edge on entry: drive lane_ready, check outputs, predict the next rising edge, then advance one cycle.
  task automatic step();
    logic [NL-1:0] r;
    bit pend, exp_rdy;
    for (int i = 0; i < NL; i++) begin
      case (ready_mode)
        0:       r[i] = 1'b1;
        1:       r[i] = 1'($urandom_range(0, 1));
        default: r[i] = !(i == 2 && stall_left > 0);
      endcase
    end
    if (stall_left > 0) stall_left--;
    bus.lane_ready = r;
    #1;
    exp_rdy = m_armed && !m_err && !m_busy();
    chk("desc_ready", 64'(bus.desc_ready), 64'(exp_rdy));
    chk("busy", 64'(busy), 64'(m_busy()));
    chk("err", 64'(err), 64'(m_err));
    for (int i = 0; i < NL; i++) begin
      pend = m_pos[i] < m_len[i];
      chk($sformatf("valid%0d", i), 64'(bus.lane_valid[i]), 64'(pend));
      chk($sformatf("cntl%0d", i), 64'(bus.lane_cntl[2*i +: 2]),
          64'(pend ? exp_cntl(m_pos[i], m_len[i]) : 2'b00));
      if (pend)
        chk($sformatf("data%0d", i), 64'(bus.lane_data[AW*i +: AW]), 64'(AW'(m_base[i] + AW'(m_pos[i]))));
    end
    acc_seen = exp_rdy && bus.desc_valid;
    for (int i = 0; i < NL; i++) if (m_pos[i] < m_len[i] && r[i]) m_pos[i]++;
    if (acc_seen) begin
      if (bus.desc_num_words == 0 || bus.desc_lane_mask == 0) m_err = 1'b1;
      else for (int i = 0; i < NL; i++) begin
        m_pos[i]  = 0;
        m_len[i]  = bus.desc_lane_mask[i] ? int'(bus.desc_num_words) : 0;
        m_base[i] = bus.desc_base_addr + AW'(i) * bus.desc_lane_stride;
      end
    end
    m_armed = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [NL-1:0] mask, input logic [AW-1:0] base,
                       input logic [AW-1:0] stride, input logic [CW-1:0] w, input bit keep);
    int n = 0;
    bus.desc_lane_mask = mask; bus.desc_base_addr = base;
    bus.desc_lane_stride = stride; bus.desc_num_words = w;
    bus.desc_valid = 1'b1;
    do begin step(); n++; end while (!acc_seen && n < 50);
    chk("accept_timeout", 64'(acc_seen), 64'(1));
    if (!keep) bus.desc_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (m_busy() && n < 300) begin step(); n++; end
    chk("drain_timeout", 64'(m_busy()), 64'(0));
    step();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_desc_ready", 64'(bus.desc_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_valid", 64'(bus.lane_valid), 64'(0));
    chk("rst_cntl", 64'(bus.lane_cntl), 64'(0));
    chk("rst_data_zero", 64'(bus.lane_data == '0), 64'(1));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    bus.desc_valid = 1'b0; bus.desc_lane_mask = '0; bus.desc_base_addr = '0;
    bus.desc_lane_stride = '0; bus.desc_num_words = '0; bus.lane_ready = '0;
    ready_mode = 0; stall_left = 0; acc_seen = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Four single-beat lanes, each framed SOD_EOD.
    offer(4'b1111, 24'h000100, 24'h10, 12'd1, 1'b0);
    drain();

    // Lane 2 stalls while lane 0 runs freely.
    ready_mode = 2; stall_left = 6;
    offer(4'b0101, 24'h20, 24'h8, 12'd4, 1'b0);
    drain();
    ready_mode = 0;

    // Address wrap inside a stream.
    offer(4'b0001, 24'hFFFFFE, 24'h0, 12'd3, 1'b0);
    drain();

    // Illegal word count: ERR is terminal, and later descriptors are ignored.
    offer(4'b0011, 24'h40, 24'h4, 12'd0, 1'b0);
    bus.desc_num_words = 12'd2; bus.desc_valid = 1'b1;
    repeat (4) step();
    bus.desc_valid = 1'b0;
    do_reset();
    offer(4'b0000, 24'h40, 24'h4, 12'd2, 1'b0);
    bus.desc_lane_mask = 4'b1111; bus.desc_valid = 1'b1;
    repeat (4) step();
    bus.desc_valid = 1'b0;
    do_reset();

    // Reset while a long stream is in flight, then start a fresh descriptor.
    offer(4'b1111, 24'h1000, 24'h100, 12'd8, 1'b0);
    step();
    do_reset();
    offer(4'b0110, 24'h2000, 24'h20, 12'd3, 1'b0);
    drain();

    // Back-to-back descriptors with desc_valid held high.
    offer(4'b1111, 24'h300, 24'h40, 12'd2, 1'b1);
    offer(4'b1010, 24'h500, 24'h40, 12'd2, 1'b0);
    drain();

    // Random descriptors under random lane backpressure.
    for (int k = 0; k < 25; k++) begin
      ready_mode = int'($urandom_range(0, 1));
      offer(NL'($urandom_range(1, 15)), AW'($urandom), AW'($urandom),
            CW'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
      if (bus.desc_valid) begin
        bus.desc_valid = 1'b0;
        repeat (int'($urandom_range(0, 3))) step();
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
